// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button front end.
package btn_pkg;

    localparam int N_BTN_DEF = 4;
    localparam int IDX_W     = $clog2(N_BTN_DEF);

    typedef logic [N_BTN_DEF-1:0] btn_vec_t;
    typedef logic [IDX_W-1:0]     btn_idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } fsm_t;

    // Fixed-priority pick: lowest set bit wins; returns 0 for an empty vector.
    function automatic btn_idx_t lowest_set(input btn_vec_t v);
        btn_idx_t r;
        r = '0;
        for (int i = N_BTN_DEF - 1; i >= 0; i--) begin
            if (v[i]) r = btn_idx_t'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button synchroniser plus debounce counter and stable-level register.
// Latency: SYNC_STAGES + DB_CYCLES cycles from raw edge to stable change.
// Backpressure: none; free-running sampler.
module btn_debounce #(
    parameter int DB_CYCLES   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   s;

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync   <= '0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
            // Any sample agreeing with the accepted level restarts the hold window.
            if (s == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
                stable <= s;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Debounces raw buttons and hands one use event per press to the LFU.
// Latency: press_pulse to use_valid is 1 cycle; back-to-back events one per cycle.
// Backpressure: use_ready low holds the offer; repeat presses merge into pending and flag ovf.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN       = N_BTN_DEF,
    parameter int DB_CYCLES   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_stable,
    output logic [N_BTN-1:0] press_pulse,
    output logic             use_valid,
    output btn_idx_t         use_idx,
    input  logic             use_ready,
    output logic             ovf,
    input  logic             ovf_clr
);

    logic [N_BTN-1:0] stable_d;
    logic [N_BTN-1:0] pend;
    logic [N_BTN-1:0] pend_nxt;
    logic [N_BTN-1:0] acc_mask;
    logic             ovf_set;
    fsm_t             state;
    fsm_t             state_nxt;
    btn_idx_t         idx_nxt;

    for (genvar i = 0; i < N_BTN; i++) begin : g_db
        btn_debounce #(
            .DB_CYCLES  (DB_CYCLES),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_db (
            .clk   (clk),
            .rst   (rst),
            .raw   (btn_raw[i]),
            .stable(btn_stable[i])
        );
    end

    assign use_valid = (state == OFFER);

    always_comb begin
        acc_mask = '0;
        if (use_valid && use_ready) acc_mask[use_idx] = 1'b1;
        // A new press on the bit being accepted stays pending (set wins).
        pend_nxt  = (pend & ~acc_mask) | press_pulse;
        ovf_set   = |(press_pulse & pend & ~acc_mask);
        state_nxt = state;
        idx_nxt   = use_idx;
        case (state)
            IDLE: begin
                if (|pend_nxt) begin
                    state_nxt = OFFER;
                    idx_nxt   = lowest_set(btn_vec_t'(pend_nxt));
                end
            end
            OFFER: begin
                if (use_ready) begin
                    if (|pend_nxt) idx_nxt = lowest_set(btn_vec_t'(pend_nxt));
                    else           state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable_d    <= '0;
            press_pulse <= '0;
            pend        <= '0;
            state       <= IDLE;
            use_idx     <= '0;
            ovf         <= 1'b0;
        end else begin
            stable_d    <= btn_stable;
            press_pulse <= btn_stable & ~stable_d;
            pend        <= pend_nxt;
            state       <= state_nxt;
            use_idx     <= idx_nxt;
            if (ovf_set)      ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Front-end stage directly upstream of the LFU tracker.
- Takes the four raw, asynchronous push-button inputs and synchronises and debounces them.
- Converts each debounced press into a single "use" event and delivers events one at a time to the LFU over a valid/ready handshake.
- Guarantees the LFU sees exactly one event per physical press, never a bounce or a metastable sample.

Parameters:
- N_BTN, 4, number of buttons; index width IDX_W = $clog2(N_BTN).
- DB_CYCLES, 8, consecutive clk cycles a synchronised level must hold before it is accepted as stable; legal range 2..255.
- SYNC_STAGES, 2, flip-flop depth of the input synchroniser; minimum 2.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- btn_raw  input  N_BTN  raw button levels, asynchronous to clk, 1 = pressed.
- btn_stable  output  N_BTN  debounced button levels.
- press_pulse  output  N_BTN  one-cycle strobe on each debounced 0->1 transition.
- use_valid  output  1  an event is presented on use_idx.
- use_idx  output  IDX_W  index of the button whose press is presented.
- use_ready  input  1  LFU accepts the event this cycle.
- ovf  output  1  sticky flag: a press was coalesced into an already-pending one.
- ovf_clr  input  1  synchronous clear for ovf.

Behaviour:
Reset:
- Applies on rst low, asynchronously; all outputs and state go to 0.
- Affected state: sync chains, debounce counters, btn_stable, press_pulse, pending mask, use_valid, use_idx, ovf.
- On release, the first posedge with rst high begins normal sampling. Reset asserted mid-handshake drops every pending event.

Synchroniser:
- Per bit, a SYNC_STAGES-deep flop chain produces s[i].

Debounce, per button i:
- Counter cnt[i] of width $clog2(DB_CYCLES+1).
- If s[i] == btn_stable[i]: cnt[i] <= 0.
- Otherwise cnt[i] increments. When cnt[i] == DB_CYCLES-1 while still differing, btn_stable[i] <= s[i] and cnt[i] <= 0.
- A glitch shorter than DB_CYCLES cycles never changes btn_stable.
- Latency from raw edge to btn_stable change: SYNC_STAGES + DB_CYCLES cycles.

Press detect:
- press_pulse[i] is high for exactly the cycle after btn_stable[i] rises: registered as btn_stable & ~btn_stable_d.
- Falling edges produce no pulse.

Pending mask pend[N_BTN]:
- pend[i] is set on press_pulse[i].
- It is cleared when the event for i is accepted, i.e. use_valid & use_ready & use_idx == i.
- If set and clear hit the same bit in the same cycle, set wins: the new press stays pending.
- A press_pulse on a bit that is already pending and not being accepted sets ovf. The press is merged, not queued.

Output handshake, two-state FSM:
- IDLE: use_valid = 0. If pend != 0, go to OFFER next cycle with use_idx = lowest set index of pend.
- OFFER: use_valid = 1; use_idx is held stable while use_ready = 0. Pend bits arriving during OFFER do not change use_idx.
  - On use_ready = 1, the event is accepted and that pend bit is cleared.
  - If further bits remain pending (after applying this cycle's sets/clears), stay in OFFER and load the next lowest index. Back-to-back events, one per cycle, are allowed.
  - Otherwise return to IDLE.
- use_ready is ignored in IDLE.
- Minimum latency from press_pulse to use_valid: 1 cycle. Arbitration is fixed priority, lowest index first.

Overflow flag:
- ovf holds until ovf_clr. When ovf_clr and a new ovf condition occur in the same cycle, set wins.

Decomposition:
- Package btn_pkg holds:
  - N_BTN_DEF = 4 and the derived IDX_W.
  - typedef btn_vec_t (logic [N_BTN-1:0]).
  - typedef btn_idx_t.
  - enum fsm_t {IDLE, OFFER}.
  - function lowest_set(btn_vec_t) returning btn_idx_t.
- One sub-module, btn_debounce: synchroniser, counter and stable register for one bit, instantiated N_BTN times via generate.
- Pending mask, arbiter, FSM and ovf live in btn_conditioner.

Test Plan:
1. Reset with rst = 0 while btn_raw = 4'b1111 -> all outputs 0; after release with btn_raw = 0, outputs stay 0 for 50 cycles.
2. btn_raw[1] pulses high for 5 cycles (< DB_CYCLES = 8) -> btn_stable, press_pulse and use_valid never assert.
3. btn_raw[2] held high with use_ready = 1 ->
   - btn_stable[2] rises 10 cycles after the raw edge;
   - press_pulse[2] high for exactly 1 cycle;
   - use_valid = 1 with use_idx = 2 for exactly 1 cycle;
   - releasing the button generates no further event.
4. Buttons 3 and 0 become stable in the same cycle with use_ready = 0 for 5 cycles, then 1 ->
   - use_idx = 0 is held for 5 cycles;
   - then use_idx = 3 for 1 cycle;
   - then use_valid = 0.
5. With use_ready = 0, press button 1, release past debounce, press again -> second press is coalesced and ovf = 1; after one acceptance use_valid drops; ovf_clr = 1 for 1 cycle -> ovf = 0.
6. Assert rst while use_valid = 1, use_idx = 2 -> use_valid, pend and ovf go to 0 immediately (asynchronously); no event is replayed after release.
